// File: rtl/ex_branch_resolve_pkg.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve_pkg
// Shared definitions for the EX-stage branch resolution unit:
//   - RISC-V conditional-branch funct3 encodings
//   - flush sequencer state type
//   - sequential PC increment
// ----------------------------------------------------------------------------
package ex_branch_resolve_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_e;

endpackage

// File: rtl/ex_branch_resolve_if.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve_if
// Bundles the EX-stage instruction/operand inputs and the redirect, BTB-update,
// flush and performance-counter outputs of ex_branch_resolve.
//   master : pipeline side (drives EX inputs, observes results)
//   slave  : resolution unit side
// Parameter CNT_W sets the counter width and must match the unit's CNT_W.
// ----------------------------------------------------------------------------
interface ex_branch_resolve_if #(
    parameter int CNT_W = 32
) ();

    // EX-stage inputs
    logic             stall_ex;
    logic             valid_ex;
    logic             is_branch_ex;
    logic             is_jal_ex;
    logic             is_jalr_ex;
    logic [2:0]       funct3_ex;
    logic [31:0]      pc_ex;
    logic [31:0]      rs1_ex;
    logic [31:0]      rs2_ex;
    logic [31:0]      imm_ex;
    logic             predicted_taken_ex;
    logic [31:0]      predicted_target_ex;

    // Redirect / BTB update / flush / counters
    logic             modify_pc_ex;
    logic [31:0]      update_pc_ex;
    logic             update_btb_ex;
    logic [31:0]      btb_update_pc_ex;
    logic             ex_branch_taken;
    logic [31:0]      jump_addr_ex;
    logic             flush_younger;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output stall_ex, valid_ex, is_branch_ex, is_jal_ex, is_jalr_ex,
               funct3_ex, pc_ex, rs1_ex, rs2_ex, imm_ex,
               predicted_taken_ex, predicted_target_ex,
        input  modify_pc_ex, update_pc_ex, update_btb_ex, btb_update_pc_ex,
               ex_branch_taken, jump_addr_ex, flush_younger,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  stall_ex, valid_ex, is_branch_ex, is_jal_ex, is_jalr_ex,
               funct3_ex, pc_ex, rs1_ex, rs2_ex, imm_ex,
               predicted_taken_ex, predicted_target_ex,
        output modify_pc_ex, update_pc_ex, update_btb_ex, btb_update_pc_ex,
               ex_branch_taken, jump_addr_ex, flush_younger,
               branch_cnt, mispredict_cnt
    );

endinterface

// File: rtl/ex_branch_resolve_branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
// Combinational conditional-branch evaluator.
// Ports:
//   funct3 in  3   branch condition encoding
//   rs1    in  32  operand 1
//   rs2    in  32  operand 2
//   cond   out 1   condition holds (0 for undefined encodings)
// ----------------------------------------------------------------------------
module branch_cond_eval
    import ex_branch_resolve_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        cond
);

    logic eq_s;
    logic lt_s;
    logic ltu_s;

    assign eq_s  = (rs1 == rs2);
    assign lt_s  = ($signed(rs1) < $signed(rs2));
    assign ltu_s = (rs1 < rs2);

    // Select the comparison named by funct3.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq_s;
            F3_BNE:  cond = ~eq_s;
            F3_BLT:  cond = lt_s;
            F3_BGE:  cond = ~lt_s;
            F3_BLTU: cond = ltu_s;
            F3_BGEU: cond = ~ltu_s;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_resolve_chk.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve_chk
// Property checker for ex_branch_resolve. Contains no functional logic.
// Ports (all inputs): clk, rst, valid_ex, stall_ex, is_branch_ex, is_jal_ex,
//                     is_jalr_ex, modify_pc_ex, update_btb_ex
// ----------------------------------------------------------------------------
module ex_branch_resolve_chk (
    input logic clk,
    input logic rst,
    input logic valid_ex,
    input logic stall_ex,
    input logic is_branch_ex,
    input logic is_jal_ex,
    input logic is_jalr_ex,
    input logic modify_pc_ex,
    input logic update_btb_ex
);

    // A live EX instruction decodes as at most one kind of control transfer.
    a_onehot_kind: assert property (@(posedge clk) disable iff (rst)
        (valid_ex && !stall_ex) |-> $onehot0({is_branch_ex, is_jal_ex, is_jalr_ex}))
        else $error("illegal EX decode: more than one of is_branch/is_jal/is_jalr");

    // A redirect always comes from a resolved control instruction.
    a_redirect_has_update: assert property (@(posedge clk) disable iff (rst)
        modify_pc_ex |-> update_btb_ex)
        else $error("redirect issued without BTB update");

endmodule

// File: rtl/ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve
// EX-stage branch/jump resolution. Evaluates condition and target of the EX
// instruction, compares against the IF-time prediction, registers redirect and
// BTB-update results (1-cycle latency) and runs a flush sequencer that holds
// flush_younger for FLUSH_CYCLES unstalled cycles after every redirect.
//
// Parameters:
//   FLUSH_CYCLES  cycles flush_younger stays high after a redirect (1..7)
//   CNT_W         performance counter width
// Ports:
//   clk   in     clock
//   rst   in     asynchronous active-high reset
//   bus   slave  ex_branch_resolve_if (EX inputs; redirect, BTB update,
//                flush_younger, branch_cnt, mispredict_cnt outputs)
// Build option:
//   BRU_PERF_CNT_EN  defined -> branch_cnt / mispredict_cnt are live counters;
//                    undefined -> both tied to zero, no counter flops.
// ----------------------------------------------------------------------------
module ex_branch_resolve
    import ex_branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic                 clk,
    input logic                 rst,
    ex_branch_resolve_if.slave  bus
);

    // Counter preload: the redirect cycle itself is the first flush cycle.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    // ---------------------------------------------------------------- resolve
    logic        cond_s;
    logic        eff_valid_s;
    logic        ctl_s;
    logic        taken_s;
    logic [31:0] jalr_sum_s;
    logic [31:0] target_s;
    logic [31:0] fallthrough_s;
    logic [31:0] next_pc_s;
    logic        mispredict_s;
    logic        redirect_s;

    // ---------------------------------------------------------------- state
    bru_state_e  state_r;
    bru_state_e  state_next_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_next_s;
    logic        flush_r;
    logic        flush_next_s;

    logic        modify_pc_r;
    logic [31:0] update_pc_r;
    logic        update_btb_r;
    logic [31:0] btb_update_pc_r;
    logic        taken_r;
    logic [31:0] jump_addr_r;

    branch_cond_eval u_cond (
        .funct3 (bus.funct3_ex),
        .rs1    (bus.rs1_ex),
        .rs2    (bus.rs2_ex),
        .cond   (cond_s)
    );

    // Only an unstalled instruction seen while IDLE is right-path and resolved.
    assign eff_valid_s   = bus.valid_ex & ~bus.stall_ex & (state_r == ST_IDLE);
    assign ctl_s         = eff_valid_s & (bus.is_branch_ex | bus.is_jal_ex | bus.is_jalr_ex);

    assign taken_s       = bus.is_jal_ex | bus.is_jalr_ex | (bus.is_branch_ex & cond_s);
    assign jalr_sum_s    = bus.rs1_ex + bus.imm_ex;
    // JALR clears bit 0 of the computed address.
    assign target_s      = bus.is_jalr_ex ? {jalr_sum_s[31:1], 1'b0}
                                          : (bus.pc_ex + bus.imm_ex);
    assign fallthrough_s = bus.pc_ex + PC_INC;
    assign next_pc_s     = taken_s ? target_s : fallthrough_s;

    // Wrong direction, or right direction (taken) but wrong target.
    assign mispredict_s  = (bus.predicted_taken_ex != taken_s) |
                           (taken_s & bus.predicted_taken_ex &
                            (bus.predicted_target_ex != target_s));
    assign redirect_s    = ctl_s & mispredict_s;

    // Flush sequencer next-state: hold on stall, count down unstalled cycles.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        flush_next_s = flush_r;
        if (bus.stall_ex) begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
            flush_next_s = flush_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_s) begin
                        state_next_s = ST_FLUSH;
                        cnt_next_s   = FLUSH_INIT;
                        flush_next_s = 1'b1;
                    end else begin
                        flush_next_s = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == 3'd0) begin
                        state_next_s = ST_IDLE;
                        flush_next_s = 1'b0;
                    end else begin
                        cnt_next_s   = cnt_r - 3'd1;
                        flush_next_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 3'd0;
                    flush_next_s = 1'b0;
                end
            endcase
        end
    end

    // Flush sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            flush_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            flush_r <= flush_next_s;
        end
    end

    // Result registers: strobes every cycle, payload only on a resolved instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modify_pc_r     <= 1'b0;
            update_pc_r     <= 32'd0;
            update_btb_r    <= 1'b0;
            btb_update_pc_r <= 32'd0;
            taken_r         <= 1'b0;
            jump_addr_r     <= 32'd0;
        end else begin
            modify_pc_r  <= redirect_s;
            update_btb_r <= ctl_s;
            if (ctl_s) begin
                update_pc_r     <= next_pc_s;
                btb_update_pc_r <= bus.pc_ex;
                taken_r         <= taken_s;
                jump_addr_r     <= target_s;
            end
        end
    end

    assign bus.modify_pc_ex     = modify_pc_r;
    assign bus.update_pc_ex     = update_pc_r;
    assign bus.update_btb_ex    = update_btb_r;
    assign bus.btb_update_pc_ex = btb_update_pc_r;
    assign bus.ex_branch_taken  = taken_r;
    assign bus.jump_addr_ex     = jump_addr_r;
    assign bus.flush_younger    = flush_r;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    // Performance counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r     <= {CNT_W{1'b0}};
            mispredict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ctl_s) begin
                branch_cnt_r <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (redirect_s) begin
                mispredict_cnt_r <= mispredict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.branch_cnt     = branch_cnt_r;
    assign bus.mispredict_cnt = mispredict_cnt_r;
`else
    assign bus.branch_cnt     = {CNT_W{1'b0}};
    assign bus.mispredict_cnt = {CNT_W{1'b0}};
`endif

    ex_branch_resolve_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .valid_ex      (bus.valid_ex),
        .stall_ex      (bus.stall_ex),
        .is_branch_ex  (bus.is_branch_ex),
        .is_jal_ex     (bus.is_jal_ex),
        .is_jalr_ex    (bus.is_jalr_ex),
        .modify_pc_ex  (modify_pc_r),
        .update_btb_ex (update_btb_r)
    );

endmodule

// File: tb/tb_ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_ex_branch_resolve
// Directed-vector bench for ex_branch_resolve (FLUSH_CYCLES=2, CNT_W=32).
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled at that same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_ex_branch_resolve;

`ifdef BRU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   br_m;
    int   mis_m;

    ex_branch_resolve_if #(.CNT_W(32)) bus ();

    ex_branch_resolve #(
        .FLUSH_CYCLES (2),
        .CNT_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic mod, input logic [31:0] upc,
                             input logic btb, input logic [31:0] bpc, input logic tk,
                             input logic [31:0] ja, input logic fl);
        check_val({tag, ".modify_pc"},  {31'd0, bus.modify_pc_ex},    {31'd0, mod});
        check_val({tag, ".update_pc"},  bus.update_pc_ex,             upc);
        check_val({tag, ".update_btb"}, {31'd0, bus.update_btb_ex},   {31'd0, btb});
        check_val({tag, ".btb_pc"},     bus.btb_update_pc_ex,         bpc);
        check_val({tag, ".taken"},      {31'd0, bus.ex_branch_taken}, {31'd0, tk});
        check_val({tag, ".jump_addr"},  bus.jump_addr_ex,             ja);
        check_val({tag, ".flush"},      {31'd0, bus.flush_younger},   {31'd0, fl});
    endtask

    task automatic check_cnt(input string tag);
        check_val({tag, ".branch_cnt"},     bus.branch_cnt,     PERF ? 32'(br_m)  : 32'd0);
        check_val({tag, ".mispredict_cnt"}, bus.mispredict_cnt, PERF ? 32'(mis_m) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
        bus.valid_ex            = 1'b1;
        bus.is_branch_ex        = br;
        bus.is_jal_ex           = jal;
        bus.is_jalr_ex          = jalr;
        bus.funct3_ex           = f3;
        bus.pc_ex               = pc;
        bus.rs1_ex              = rs1;
        bus.rs2_ex              = rs2;
        bus.imm_ex              = imm;
        bus.predicted_taken_ex  = pt;
        bus.predicted_target_ex = ptgt;
    endtask

    task automatic bubble();
        bus.valid_ex     = 1'b0;
        bus.is_branch_ex = 1'b0;
        bus.is_jal_ex    = 1'b0;
        bus.is_jalr_ex   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        br_m     = 0;
        mis_m    = 0;
        rst      = 1'b1;
        bus.stall_ex = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        bubble();

        // Reset state
        tick();
        tick();
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_cnt("reset");
        rst = 1'b0;
        tick();

        // BEQ equal, predicted not-taken -> redirect to 0x120, 2-cycle flush
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
        tick();
        br_m++; mis_m++;
        check_out("beq", 1'b1, 32'h120, 1'b1, 32'h100, 1'b1, 32'h120, 1'b1);
        bubble();
        tick();
        check_out("beq_f1", 1'b0, 32'h120, 1'b0, 32'h100, 1'b1, 32'h120, 1'b1);
        tick();
        check_out("beq_f2", 1'b0, 32'h120, 1'b0, 32'h100, 1'b1, 32'h120, 1'b0);
        check_cnt("beq");

        // BNE equal operands, predicted taken -> redirect to fallthrough
        drive(1'b1, 1'b0, 1'b0, 3'b001, 32'h200, 32'd7, 32'd7, 32'h40, 1'b1, 32'h240);
        tick();
        br_m++; mis_m++;
        check_out("bne", 1'b1, 32'h204, 1'b1, 32'h200, 1'b0, 32'h240, 1'b1);
        bubble();
        tick();
        tick();
        check_val("bne_f2.flush", {31'd0, bus.flush_younger}, 32'd0);

        // BLT signed -1 < 1, correctly predicted; then BLTU same operands not taken
        drive(1'b1, 1'b0, 1'b0, 3'b100, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h310);
        tick();
        br_m++;
        check_out("blt", 1'b0, 32'h310, 1'b1, 32'h300, 1'b1, 32'h310, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b110, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 32'h410);
        tick();
        br_m++; mis_m++;
        check_out("bltu", 1'b1, 32'h404, 1'b1, 32'h400, 1'b0, 32'h410, 1'b1);
        bubble();
        tick();
        tick();
        check_cnt("blt");

        // JAL backwards, correctly predicted; then JALR with odd sum and wrong target
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h700, 32'd0, 32'd0, 32'hFFFF_FFF0, 1'b1, 32'h6F0);
        tick();
        br_m++;
        check_out("jal", 1'b0, 32'h6F0, 1'b1, 32'h700, 1'b1, 32'h6F0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h500, 32'h1003, 32'd0, 32'h10, 1'b1, 32'h1010);
        tick();
        br_m++; mis_m++;
        check_out("jalr", 1'b1, 32'h1012, 1'b1, 32'h500, 1'b1, 32'h1012, 1'b1);

        // Wrong-path branches during the flush window are ignored
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h600, 32'd3, 32'd3, 32'h8, 1'b0, 32'h0);
        tick();
        check_out("shadow1", 1'b0, 32'h1012, 1'b0, 32'h500, 1'b1, 32'h1012, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h604, 32'd3, 32'd3, 32'h8, 1'b0, 32'h0);
        tick();
        check_out("shadow2", 1'b0, 32'h1012, 1'b0, 32'h500, 1'b1, 32'h1012, 1'b0);
        bubble();
        tick();
        check_val("shadow3.update_btb", {31'd0, bus.update_btb_ex}, 32'd0);
        check_cnt("shadow");

        // Address wrap: target wraps to 0x4, fallthrough wraps to 0x0
        drive(1'b1, 1'b0, 1'b0, 3'b101, 32'hFFFF_FFFC, 32'd1, 32'h8000_0000, 32'h8, 1'b0, 32'h0);
        tick();
        br_m++; mis_m++;
        check_out("bge_wrap", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4, 1'b1);
        bubble();
        tick();
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFC, 32'd1, 32'h8000_0000, 32'h8, 1'b1, 32'h4);
        tick();
        br_m++; mis_m++;
        check_out("bgeu_wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h4, 1'b1);
        bubble();
        tick();
        tick();

        // Undefined funct3 is not-taken; predicted not-taken so no redirect
        drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h900, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
        tick();
        br_m++;
        check_out("f3_undef", 1'b0, 32'h904, 1'b1, 32'h900, 1'b0, 32'h940, 1'b0);

        // Valid non-control instruction: no update, payload held
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'hA00, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
        tick();
        check_out("alu", 1'b0, 32'h904, 1'b0, 32'h900, 1'b0, 32'h940, 1'b0);

        // Stalled branch in IDLE is not evaluated
        bus.stall_ex = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'hB00, 32'd5, 32'd5, 32'h10, 1'b0, 32'h0);
        tick();
        check_out("stall_idle", 1'b0, 32'h904, 1'b0, 32'h900, 1'b0, 32'h940, 1'b0);
        check_cnt("stall_idle");

        // Released: redirect, then stall 3 cycles inside the flush window
        bus.stall_ex = 1'b0;
        tick();
        br_m++; mis_m++;
        check_out("stall_pre", 1'b1, 32'hB10, 1'b1, 32'hB00, 1'b1, 32'hB10, 1'b1);
        bus.stall_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("stall_f%0d", i), 1'b0, 32'hB10, 1'b0, 32'hB00, 1'b1, 32'hB10, 1'b1);
        end
        bus.stall_ex = 1'b0;
        bubble();
        tick();
        check_val("stall_u1.flush", {31'd0, bus.flush_younger}, 32'd1);
        tick();
        check_val("stall_u2.flush", {31'd0, bus.flush_younger}, 32'd0);
        check_cnt("stall");

        // Asynchronous reset in the middle of a flush
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'hC00, 32'd5, 32'd5, 32'h10, 1'b0, 32'h0);
        tick();
        br_m++; mis_m++;
        check_val("rst_pre.flush", {31'd0, bus.flush_younger}, 32'd1);
        bubble();
        #2;
        rst = 1'b1;
        #1;
        br_m = 0; mis_m = 0;
        check_out("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_cnt("rst_async");
        tick();
        rst = 1'b0;
        tick();
        check_val("rst_noresid.flush", {31'd0, bus.flush_younger}, 32'd0);

        // Operational after reset: correctly predicted BEQ
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'hD00, 32'd5, 32'd5, 32'h4, 1'b1, 32'hD04);
        tick();
        br_m++;
        check_out("post_rst", 1'b0, 32'hD04, 1'b1, 32'hD00, 1'b1, 32'hD04, 1'b0);
        check_cnt("post_rst");
        bubble();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_branch_resolve.md
Name: ex_branch_resolve

Overview:
- EX-stage branch/jump resolution unit; produces the redirect and BTB-update signals consumed by the IF stage.
  - redirect: modify_pc_ex, update_pc_ex
  - BTB update: update_btb_ex, btb_update_pc_ex, ex_branch_taken, jump_addr_ex
- Evaluates the branch condition and target, compares them with the IF-time prediction, registers the outcome, and runs a wrong-path flush sequencer that squashes younger instructions.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_younger stays high after a redirect (1..7).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall_ex  in  1  EX held by hazard unit; no evaluation, state frozen
- valid_ex  in  1  EX slot holds a real instruction
- is_branch_ex  in  1  conditional branch
- is_jal_ex  in  1  JAL
- is_jalr_ex  in  1  JALR
- funct3_ex  in  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- pc_ex  in  32  PC of EX instruction
- rs1_ex  in  32  operand 1
- rs2_ex  in  32  operand 2
- imm_ex  in  32  sign-extended immediate
- predicted_taken_ex  in  1  IF-time BTB prediction, piped to EX
- predicted_target_ex  in  32  IF-time predicted target, piped to EX
- modify_pc_ex  out  1  redirect strobe to IF
- update_pc_ex  out  32  redirect PC
- update_btb_ex  out  1  BTB write enable
- btb_update_pc_ex  out  32  PC of resolved control instruction (IF indexes [31:2])
- ex_branch_taken  out  1  actual outcome
- jump_addr_ex  out  32  actual taken target
- flush_younger  out  1  squash IF/ID and ID/EX
- branch_cnt  out  CNT_W  resolved control instructions
- mispredict_cnt  out  CNT_W  redirects issued

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high. On reset, all outputs are 0 and the FSM is IDLE.
- Control instruction (ctl): eff_valid = valid_ex & ~stall_ex & (state==IDLE); ctl = eff_valid & (is_branch_ex|is_jal_ex|is_jalr_ex). Exactly one is_* is high; more than one is illegal (an assertion flags it).
- Combinational resolution:
  - taken = jal | jalr | (branch & cond). cond uses signed compare for BLT/BGE and unsigned for BLTU/BGEU. Undefined funct3 gives not-taken.
  - target = jalr ? ((rs1+imm) & ~1) : (pc_ex+imm); 32-bit arithmetic, wraps mod 2^32.
  - fallthrough = pc_ex+4, wraps.
- Mispredict: predicted_taken_ex != taken, OR (taken & predicted_taken_ex & predicted_target_ex != target).
- Registered outputs, latency 1 cycle after an EX evaluation edge:
  - update_btb_ex = ctl.
  - btb_update_pc_ex = pc_ex, ex_branch_taken = taken, jump_addr_ex = target; these hold their values when update_btb_ex=0.
  - modify_pc_ex = ctl & mispredict; it is a single-cycle pulse.
  - update_pc_ex = taken ? target : fallthrough.
- Flush FSM (3-bit cnt):
  - IDLE: a mispredict on a ctl cycle sets modify_pc_ex, flush_younger=1 and cnt=FLUSH_CYCLES-1, then goes to FLUSH. If FLUSH_CYCLES==1, it returns to IDLE on the next edge.
  - FLUSH: flush_younger=1; cnt decrements each non-stalled cycle; at cnt==0 the next edge drops flush_younger and goes to IDLE.
  - While in FLUSH, EX content is wrong-path: it is never evaluated and produces no update or redirect.
- stall_ex: freezes the FSM, cnt and counters. Registered strobes (modify_pc_ex, update_btb_ex) deassert on a stalled cycle; they are never repeated.
- Counters (see Optional Feature): branch_cnt += ctl; mispredict_cnt += ctl & mispredict; both wrap at 2^CNT_W.
- Reset mid-FLUSH returns the FSM to IDLE immediately; no residual flush.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
  - Defined: branch_cnt and mispredict_cnt are implemented as above.
  - Undefined: both ports are tied to 0 and no counter flops are synthesised. Ports are always present.

Decomposition:
- Shared package: funct3 branch encodings, FSM state typedef {IDLE, FLUSH}, PC_INC=4.
- One sub-module, branch_cond_eval: combinational funct3/rs1/rs2 → cond. Everything else stays in the top.

Test Plan:
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred not taken → next cycle: modify_pc_ex=1, update_pc_ex=0x120, update_btb_ex=1, ex_branch_taken=1, btb_update_pc_ex=0x100; flush_younger high 2 cycles.
- BNE rs1=rs2, pc=0x200, pred taken target 0x240 → modify_pc_ex=1, update_pc_ex=0x204, ex_branch_taken=0.
- BLT rs1=0xFFFFFFFF, rs2=1, pred taken to correct target → no redirect, update_btb_ex=1, taken=1. Same operands with BLTU → not taken, redirect to pc+4.
- JALR rs1=0x1003, imm=0x10, pred taken target 0x1010 → target 0x1012, redirect to 0x1012.
- Mispredict followed by valid branches in the next 2 cycles → those produce no update_btb_ex or modify_pc_ex; branch_cnt increments by 1 only.
- stall_ex held 3 cycles during FLUSH → flush_younger stays high 2 unstalled cycles; rst asserted mid-FLUSH → all outputs 0 asynchronously.
